bus_arbiter_rr: RTL and testbench
=================================

Name: bus_arbiter_rr

Overview:
- Parametrised successor to the fixed-priority bus-access arbiter.
- Arbitrates bus access for N_MASTERS master devices using a barq/bagd handshake, with address-valid, target-ready and data-strobe negotiation plus a timeout error.
- Adds:
  - selectable fixed or round-robin priority
  - per-master bus lock for back-to-back transfers, with a configurable lock limit
  - parametrised timeout
  - encoded grant index output
  - saturating error counter
- Sits between the master devices and the shared local bus decoder.

Parameters:
- N_MASTERS, 4, number of requesting masters (2..16).
- TIMEOUT_CYCLES, 10, WAIT cycles before a forced strobe with error (1..2**TO_W-1).
- TO_W, 8, timeout counter width.
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (highest index wins).
- LOCK_MAX, 4, maximum consecutive locked transfers before forced release (≥1).
- ERRCNT_W, 8, error counter width.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous reset, active high.
- barq, in, N_MASTERS, bus access requests, level.
- lock, in, N_MASTERS, request to keep the grant after the current transfer.
- bagd, out, N_MASTERS, one-hot bus access granted.
- grant_id, out, $clog2(N_MASTERS), index of the granted master; valid while busy.
- busy, out, 1, arbiter not in IDLE.
- address_valid, out, 1, target address decode enable.
- target_ready, in, 1, target device ready, level.
- data_strobe, out, 1, one-cycle pulse completing a transfer.
- error, out, 1, one-cycle pulse coincident with data_strobe when the transfer timed out.
- err_count, out, ERRCNT_W, saturating count of timeouts.

Behaviour:
- One clock; reset is synchronous and active-high.
- All outputs are registered or decoded from registered state only.
- Reset values:
  - state=IDLE; all outputs 0
  - rr_ptr=N_MASTERS-1, so index 0 has first priority
  - eligibility mask all 1; lock_cnt=0; err_count=0
- Reset mid-transfer aborts immediately, with no strobe and no error.

Eligibility:
- req_e = barq & elig_mask.
- The released master's elig bit clears in RELEASE.
- It sets again once that master's barq is 0, so a master must drop barq before re-arbitrating.

Winner selection:
- Fixed mode: highest set index of req_e.
- RR mode: first set index of req_e scanning upward from rr_ptr+1, wrapping modulo N_MASTERS.
- rr_ptr loads the winner index on every new (non-lock) grant.

States:
- IDLE: if req_e≠0, latch winner into grant_id → ADDR.
- ADDR (1 cycle): bagd[grant_id]=1, address_valid=0; clear timeout counter → WAIT.
- WAIT: bagd held, address_valid=1; counter increments each cycle.
  - If target_ready=1 → STROBE, to_flag=0.
  - Else if cnt==TIMEOUT_CYCLES-1 → STROBE, to_flag=1.
  - If target_ready=1 on the timeout cycle, ready wins (no error).
- STROBE (1 cycle): data_strobe=1, error=to_flag, bagd held.
  - If error, err_count++ (saturates at all-ones).
  - If lock[grant_id]=1 and barq[grant_id]=1 and lock_cnt<LOCK_MAX-1: lock_cnt++ → ADDR, same grant, no re-arbitration.
  - Otherwise lock_cnt=0 → RELEASE.
- RELEASE (1 cycle): bagd=0, address_valid=0, clear elig bit of grant_id → IDLE.

Other rules:
- A master dropping barq while granted does not abort; the transfer completes via ready or timeout.
- Latency from barq rising in IDLE (cycle 0):
  - bagd at cycle 1, address_valid at cycle 2
  - earliest data_strobe at cycle 3, when target_ready=1 at cycle 2
  - bagd low at cycle 4
  - next grant at cycle 6
- Locked re-grant: ADDR in the cycle after STROBE.

Decomposition:
- Package bus_arb_pkg holds:
  - typedef enum arb_state_t {IDLE, ADDR, WAIT, STROBE, RELEASE}
  - default parameter constants
  - function onehot(idx)
- Sub-module rr_priority_select: combinational winner picker.
  - Inputs: req, ptr, rr_mode.
  - Outputs: any, idx.
  - Unit-tested separately.

Test Plan:
- Single request: barq=4'b0010, target_ready rises 2 cycles after address_valid → bagd=0010 at cycle 1, address_valid cycle 2, data_strobe cycle 5, error=0, bagd=0 cycle 6.
- Timeout: barq=4'b0001, target_ready held 0 → data_strobe and error high together after exactly 10 WAIT cycles; err_count=1.
- Round-robin fairness: barq=4'b1111 held, with each master dropping barq after its RELEASE for one cycle → grant order 0,1,2,3,0 (RR_MODE=1); with RR_MODE=0, 3 wins first.
- Lock limit: barq[2]=lock[2]=1 held, LOCK_MAX=4 → four strobes with grant_id=2 and no RELEASE between, then RELEASE; master 1 pending is granted next.
- Ready on timeout cycle: target_ready=1 exactly at cnt=9 → data_strobe=1, error=0, err_count unchanged.
- Reset in WAIT: assert reset one cycle → next cycle all outputs 0, state IDLE, no strobe; err_count=0.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and defaults for the round-robin bus arbiter.
package bus_arb_pkg;

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, STROBE, RELEASE} arb_state_t;

  localparam int MAX_MASTERS        = 16;
  localparam int DEF_N_MASTERS      = 4;
  localparam int DEF_TIMEOUT_CYCLES = 10;
  localparam int DEF_TO_W           = 8;
  localparam int DEF_RR_MODE        = 1;
  localparam int DEF_LOCK_MAX       = 4;
  localparam int DEF_ERRCNT_W       = 8;

  function automatic logic [MAX_MASTERS-1:0] onehot(input logic [3:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational winner picker: highest index in fixed mode, or first request
// above ptr (wrapping) in round-robin mode.
module rr_priority_select #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             rr_mode,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  int   j;
  logic found;

  always_comb begin
    any   = |req;
    idx   = '0;
    j     = 0;
    found = 1'b0;
    if (!rr_mode) begin
      // later assignments win, so the highest set index is kept
      for (int i = 0; i < N; i++) begin
        if (req[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        j = (int'(ptr) + k) % N;
        if (!found && req[j]) begin
          idx   = IDX_W'(j);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Bus-access arbiter with fixed/round-robin priority, bus lock, timeout and
// saturating error count; all outputs decoded from registered state.
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int N_MASTERS      = DEF_N_MASTERS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TO_W           = DEF_TO_W,
  parameter int RR_MODE        = DEF_RR_MODE,
  parameter int LOCK_MAX       = DEF_LOCK_MAX,
  parameter int ERRCNT_W       = DEF_ERRCNT_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_MASTERS-1:0]         barq,
  input  logic [N_MASTERS-1:0]         lock,
  output logic [N_MASTERS-1:0]         bagd,
  output logic [$clog2(N_MASTERS)-1:0] grant_id,
  output logic                         busy,
  output logic                         address_valid,
  input  logic                         target_ready,
  output logic                         data_strobe,
  output logic                         error,
  output logic [ERRCNT_W-1:0]          err_count
);

  localparam int IDX_W = $clog2(N_MASTERS);
  localparam int LC_W  = $clog2(LOCK_MAX + 1);

  arb_state_t           state_q, state_d;
  logic [IDX_W-1:0]     grant_id_q, grant_id_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [N_MASTERS-1:0] elig_q, elig_d;
  logic [LC_W-1:0]      lock_cnt_q, lock_cnt_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic                 to_flag_q, to_flag_d;
  logic [ERRCNT_W-1:0]  err_count_q, err_count_d;

  logic                   win_any;
  logic [IDX_W-1:0]       win_idx;
  logic [MAX_MASTERS-1:0] grant_vec;

  rr_priority_select #(.N(N_MASTERS), .IDX_W(IDX_W)) u_sel (
    .req     (barq & elig_q),
    .ptr     (rr_ptr_q),
    .rr_mode (RR_MODE != 0),
    .any     (win_any),
    .idx     (win_idx)
  );

  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    lock_cnt_d  = lock_cnt_q;
    to_cnt_d    = to_cnt_q;
    to_flag_d   = to_flag_q;
    err_count_d = err_count_q;
    // a master regains eligibility only after it has dropped its request
    elig_d      = elig_q | ~barq;

    unique case (state_q)
      IDLE: begin
        if (win_any) begin
          grant_id_d = win_idx;
          rr_ptr_d   = win_idx;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        to_cnt_d = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        if (target_ready) begin
          to_flag_d = 1'b0;
          state_d   = STROBE;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          to_flag_d = 1'b1;
          state_d   = STROBE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      STROBE: begin
        if (to_flag_q && (err_count_q != '1)) err_count_d = err_count_q + 1'b1;
        if (lock[grant_id_q] && barq[grant_id_q] && (lock_cnt_q < LC_W'(LOCK_MAX - 1))) begin
          lock_cnt_d = lock_cnt_q + 1'b1;
          state_d    = ADDR;
        end else begin
          lock_cnt_d = '0;
          state_d    = RELEASE;
        end
      end
      RELEASE: begin
        elig_d[grant_id_q] = 1'b0;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_id_q  <= '0;
      rr_ptr_q    <= IDX_W'(N_MASTERS - 1);
      elig_q      <= '1;
      lock_cnt_q  <= '0;
      to_cnt_q    <= '0;
      to_flag_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      elig_q      <= elig_d;
      lock_cnt_q  <= lock_cnt_d;
      to_cnt_q    <= to_cnt_d;
      to_flag_q   <= to_flag_d;
      err_count_q <= err_count_d;
    end
  end

  always_comb begin
    grant_vec     = onehot(4'(grant_id_q));
    bagd          = '0;
    if (state_q inside {ADDR, WAIT, STROBE}) bagd = grant_vec[N_MASTERS-1:0];
    grant_id      = grant_id_q;
    busy          = (state_q != IDLE);
    address_valid = (state_q == WAIT);
    data_strobe   = (state_q == STROBE);
    error         = (state_q == STROBE) && to_flag_q;
    err_count     = err_count_q;
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: strobe scoreboard plus cycle-exact checks.
module tb_bus_arbiter_rr;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] barq = '0;
  logic [3:0] lock = '0;
  logic       target_ready = 1'b0;

  logic [3:0] bagd, bagd_f;
  logic [1:0] gid, gid_f;
  logic       busy, busy_f, av, av_f, ds, ds_f, er, er_f;
  logic [7:0] ec, ec_f;

  typedef struct packed {
    logic [1:0] gid;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   order[5] = '{0, 1, 2, 3, 0};
  logic [3:0] mask;

  always #5 clk = ~clk;

  bus_arbiter_rr #(.RR_MODE(1)) dut (
    .clk(clk), .reset(reset), .barq(barq), .lock(lock), .bagd(bagd),
    .grant_id(gid), .busy(busy), .address_valid(av), .target_ready(target_ready),
    .data_strobe(ds), .error(er), .err_count(ec)
  );

  bus_arbiter_rr #(.RR_MODE(0)) dut_fp (
    .clk(clk), .reset(reset), .barq(barq), .lock(lock), .bagd(bagd_f),
    .grant_id(gid_f), .busy(busy_f), .address_valid(av_f), .target_ready(target_ready),
    .data_strobe(ds_f), .error(er_f), .err_count(ec_f)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; barq = '0; lock = '0; target_ready = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  // every completed transfer must match the next expected one
  always @(negedge clk) begin
    if (!reset && ds) begin
      chk("strobe_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("strobe_gid", gid, mon_e.gid);
        chk("strobe_err", er, mon_e.err);
      end
    end
  end

  initial begin
    step(3);
    chk("rst_bagd", bagd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_av", av, 0);
    chk("rst_ds", ds, 0);
    chk("rst_err", er, 0);
    chk("rst_gid", gid, 0);
    chk("rst_ec", ec, 0);
    reset = 1'b0;
    step(1);

    // single request, ready two cycles after address_valid
    barq = 4'b0010; exp_q.push_back('{2'd1, 1'b0});
    step(1);
    chk("t1_bagd", bagd, 4'b0010); chk("t1_av0", av, 0);
    chk("t1_gid", gid, 1); chk("t1_busy", busy, 1);
    step(1);
    chk("t1_av", av, 1); chk("t1_bagd2", bagd, 4'b0010);
    step(1);
    chk("t1_ds_early", ds, 0);
    step(1); target_ready = 1'b1;
    step(1);
    chk("t1_ds", ds, 1); chk("t1_err", er, 0);
    target_ready = 1'b0; barq = '0;
    step(1);
    chk("t1_rel_bagd", bagd, 0); chk("t1_rel_busy", busy, 1);
    step(1);
    chk("t1_idle", busy, 0);

    // timeout after ten WAIT cycles
    barq = 4'b0001; exp_q.push_back('{2'd0, 1'b1});
    step(2);
    chk("t2_av", av, 1);
    step(9);
    chk("t2_no_ds", ds, 0);
    step(1);
    chk("t2_ds", ds, 1); chk("t2_err", er, 1);
    barq = '0;
    step(1);
    chk("t2_ec", ec, 1);
    step(2);

    // ready arriving exactly on the timeout cycle wins
    barq = 4'b0001; exp_q.push_back('{2'd0, 1'b0});
    step(2);
    step(9); target_ready = 1'b1;
    step(1);
    chk("t3_ds", ds, 1); chk("t3_err", er, 0);
    target_ready = 1'b0; barq = '0;
    step(1);
    chk("t3_ec", ec, 1);
    step(2);

    // lock limit: four back-to-back transfers for master 2, then master 1
    target_ready = 1'b1; barq = 4'b0100; lock = 4'b0100;
    repeat (4) exp_q.push_back('{2'd2, 1'b0});
    exp_q.push_back('{2'd1, 1'b0});
    step(1);
    barq = 4'b0110;
    chk("t4_gid", gid, 2);
    for (int c = 1; c <= 12; c++) begin
      chk("t4_hold_bagd", bagd, 4'b0100);
      step(1);
    end
    chk("t4_rel_bagd", bagd, 0);
    barq = 4'b0010; lock = '0;
    step(2);
    chk("t4_next_gid", gid, 1); chk("t4_next_bagd", bagd, 4'b0010);
    barq = '0;
    step(2);
    chk("t4_next_ds", ds, 1);
    step(3);
    target_ready = 1'b0;
    chk("t4_queue_drained", exp_q.size(), 0);
    do_reset();

    // round-robin fairness vs fixed priority
    target_ready = 1'b1; barq = 4'b1111;
    step(1);
    chk("t5_fixed_gid", gid_f, 3); chk("t5_fixed_bagd", bagd_f, 4'b1000);
    for (int k = 0; k < 5; k++) begin
      mask = 4'b0001 << order[k];
      chk("t5_gid", gid, order[k]);
      chk("t5_bagd", bagd, mask);
      exp_q.push_back('{2'(order[k]), 1'b0});
      step(3);
      chk("t5_rel_bagd", bagd, 0);
      step(1);
      if (k == 4) barq = '0;
      else barq[order[k]] = 1'b0;
      step(1);
      if (k != 4) barq[order[k]] = 1'b1;
    end
    target_ready = 1'b0;
    step(3);
    chk("t5_queue_drained", exp_q.size(), 0);

    // reset while waiting aborts the transfer silently
    barq = 4'b0001;
    step(2);
    chk("t6_av", av, 1);
    step(2);
    reset = 1'b1; barq = '0;
    step(1);
    chk("t6_bagd", bagd, 0); chk("t6_busy", busy, 0); chk("t6_av0", av, 0);
    chk("t6_ds", ds, 0); chk("t6_err", er, 0); chk("t6_gid", gid, 0);
    chk("t6_ec", ec, 0);
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step(1);
      chk("t6_quiet_ds", ds, 0);
      chk("t6_quiet_busy", busy, 0);
    end
    chk("final_queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
